// File: rtl/fas_pkg.sv
// Shared types and sizes for the FAS frequency-analysis stage.
// Bins are {re, im} pairs of signed 8.8 values.
package fas_pkg;

  localparam int NBIN = 16;
  localparam int DW   = 16;
  localparam int MAGW = 32;
  localparam int IDXW = $clog2(NBIN);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBIN - 1);

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/fas_mag_sq.sv
// Combinational squared magnitude re^2 + im^2 of one complex bin.
// The result is unsigned, so the full-scale case 2 * (-2^15)^2 = 2^31 still fits.
module fas_mag_sq
  import fas_pkg::*;
(
  input  logic signed [DW-1:0]   re,
  input  logic signed [DW-1:0]   im,
  output logic        [MAGW-1:0] mag
);

  logic signed [2*DW-1:0] re_x_s;
  logic signed [2*DW-1:0] im_x_s;
  logic signed [2*DW-1:0] re_sq_s;
  logic signed [2*DW-1:0] im_sq_s;

  // Sign-extend first so each square is computed exactly at full width.
  always_comb begin
    re_x_s  = {{DW{re[DW-1]}}, re};
    im_x_s  = {{DW{im[DW-1]}}, im};
    re_sq_s = re_x_s * re_x_s;
    im_sq_s = im_x_s * im_x_s;
    mag     = MAGW'($unsigned(re_sq_s)) + MAGW'($unsigned(im_sq_s));
  end

endmodule

// File: rtl/fas_freq_analysis.sv
// Peak-bin finder for 16-point FFT frames: captures a frame, scans one bin per cycle
// through a single squarer, and reports the index of the largest |X|^2.
module fas_freq_analysis
  import fas_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                fft_valid,
  input  logic [2*DW-1:0]     fft_d0,
  input  logic [2*DW-1:0]     fft_d1,
  input  logic [2*DW-1:0]     fft_d2,
  input  logic [2*DW-1:0]     fft_d3,
  input  logic [2*DW-1:0]     fft_d4,
  input  logic [2*DW-1:0]     fft_d5,
  input  logic [2*DW-1:0]     fft_d6,
  input  logic [2*DW-1:0]     fft_d7,
  input  logic [2*DW-1:0]     fft_d8,
  input  logic [2*DW-1:0]     fft_d9,
  input  logic [2*DW-1:0]     fft_d10,
  input  logic [2*DW-1:0]     fft_d11,
  input  logic [2*DW-1:0]     fft_d12,
  input  logic [2*DW-1:0]     fft_d13,
  input  logic [2*DW-1:0]     fft_d14,
  input  logic [2*DW-1:0]     fft_d15,
  output logic [IDXW-1:0]     freq,
  output logic                done,
  output logic                busy,
  output logic                overrun
);

  cplx_t            frame_s [NBIN];
  cplx_t            work_r  [NBIN];
  cplx_t            bin_s;
  state_t           state_r;
  state_t           state_nx_s;
  logic [IDXW-1:0]  idx_r;
  logic             scan_end_s;
  logic             accept_s;
  logic [MAGW-1:0]  mag_s;
  logic [MAGW-1:0]  mag_r;
  logic             mag_vld_r;
  logic             mag_first_r;
  logic             mag_last_r;
  logic [IDXW-1:0]  mag_tag_r;
  logic [MAGW-1:0]  best_r;
  logic [IDXW-1:0]  best_idx_r;
  logic             take_s;
  logic [MAGW-1:0]  win_mag_s;
  logic [IDXW-1:0]  win_idx_s;

  // Gather the flat input ports into an indexable frame.
  always_comb begin
    frame_s[0]  = fft_d0;   frame_s[1]  = fft_d1;   frame_s[2]  = fft_d2;   frame_s[3]  = fft_d3;
    frame_s[4]  = fft_d4;   frame_s[5]  = fft_d5;   frame_s[6]  = fft_d6;   frame_s[7]  = fft_d7;
    frame_s[8]  = fft_d8;   frame_s[9]  = fft_d9;   frame_s[10] = fft_d10;  frame_s[11] = fft_d11;
    frame_s[12] = fft_d12;  frame_s[13] = fft_d13;  frame_s[14] = fft_d14;  frame_s[15] = fft_d15;
  end

  // Accept decision and next state; a new frame may land on the last scan cycle.
  always_comb begin
    scan_end_s = (state_r == ST_SCAN) && (idx_r == LAST_IDX);
    accept_s   = fft_valid && ((state_r == ST_IDLE) || scan_end_s);
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nx_s = ST_SCAN;
        else          state_nx_s = ST_IDLE;
      end
      ST_SCAN: begin
        if (scan_end_s && !accept_s) state_nx_s = ST_IDLE;
        else                         state_nx_s = ST_SCAN;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Controller state, bin counter, frame capture and sticky overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      idx_r   <= '0;
      busy    <= 1'b0;
      overrun <= 1'b0;
      for (int i = 0; i < NBIN; i++) work_r[i] <= '0;
    end else begin
      state_r <= state_nx_s;
      busy    <= (state_nx_s == ST_SCAN);
      if (accept_s) begin
        idx_r <= '0;
        for (int i = 0; i < NBIN; i++) work_r[i] <= frame_s[i];
      end else if (state_r == ST_SCAN) begin
        idx_r <= idx_r + IDXW'(1);
      end
      if (fft_valid && !accept_s) overrun <= 1'b1;
    end
  end

  always_comb begin
    bin_s = work_r[idx_r];
  end

  fas_mag_sq u_mag_sq (
    .re  (bin_s.re),
    .im  (bin_s.im),
    .mag (mag_s)
  );

  // Magnitude stage; frame-tag flags ride along so drain and next scan can overlap.
  always_ff @(posedge clk) begin
    if (rst) begin
      mag_r       <= '0;
      mag_vld_r   <= 1'b0;
      mag_first_r <= 1'b0;
      mag_last_r  <= 1'b0;
      mag_tag_r   <= '0;
    end else begin
      mag_vld_r   <= (state_r == ST_SCAN);
      mag_first_r <= (state_r == ST_SCAN) && (idx_r == '0);
      mag_last_r  <= scan_end_s;
      if (state_r == ST_SCAN) begin
        mag_r     <= mag_s;
        mag_tag_r <= idx_r;
      end
    end
  end

  // Strict greater-than keeps the lower index on ties.
  always_comb begin
    take_s    = mag_first_r || (mag_r > best_r);
    win_mag_s = take_s ? mag_r     : best_r;
    win_idx_s = take_s ? mag_tag_r : best_idx_r;
  end

  // Running maximum and result publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_r     <= '0;
      best_idx_r <= '0;
      freq       <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (mag_vld_r) begin
        best_r     <= win_mag_s;
        best_idx_r <= win_idx_s;
        if (mag_last_r) begin
          freq <= win_idx_s;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fas_freq_analysis.sv
// Directed bench for fas_freq_analysis: single frames, ties, full-scale values,
// back-to-back frames, overrun and reset in mid-scan.
module tb_fas_freq_analysis;

  logic        clk = 1'b0;
  logic        rst;
  logic        fft_valid;
  logic [31:0] frm [16];
  logic [3:0]  freq;
  logic        done;
  logic        busy;
  logic        overrun;

  int n_vec = 0;
  int n_err = 0;
  int ndone;
  logic [3:0] last_freq;

  always #5 clk = ~clk;

  fas_freq_analysis dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(frm[0]),   .fft_d1(frm[1]),   .fft_d2(frm[2]),   .fft_d3(frm[3]),
    .fft_d4(frm[4]),   .fft_d5(frm[5]),   .fft_d6(frm[6]),   .fft_d7(frm[7]),
    .fft_d8(frm[8]),   .fft_d9(frm[9]),   .fft_d10(frm[10]), .fft_d11(frm[11]),
    .fft_d12(frm[12]), .fft_d13(frm[13]), .fft_d14(frm[14]), .fft_d15(frm[15]),
    .freq(freq), .done(done), .busy(busy), .overrun(overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_frame();
    for (int i = 0; i < 16; i++) frm[i] = 32'h0;
  endtask

  // Strobe the currently loaded frame for one cycle (edge E0), then clear the inputs.
  task automatic strobe();
    fft_valid = 1'b1;
    tick();
    fft_valid = 1'b0;
    clear_frame();
  endtask

  // After strobe() (now past E0): expect quiet through E16, done at E17, hold at E18.
  task automatic expect_result(input string tag, input logic [3:0] exp_freq);
    ticks(16);
    chk({tag, "_nodone_e16"}, 32'(done), 32'd0);
    tick();
    chk({tag, "_done_e17"}, 32'(done), 32'd1);
    chk({tag, "_freq"}, 32'(freq), 32'(exp_freq));
    chk({tag, "_busy_e17"}, 32'(busy), 32'd0);
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_freq_hold"}, 32'(freq), 32'(exp_freq));
  endtask

  initial begin
    rst = 1'b1;
    fft_valid = 1'b0;
    clear_frame();
    ticks(2);
    chk("rst_freq", 32'(freq), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    tick();

    // 1: single peak at bin 5 (|X|^2 = 9+16 in 8.8 units)
    frm[5] = 32'h0300_0400;
    strobe();
    chk("t1_busy", 32'(busy), 32'd1);
    expect_result("t1", 4'd5);

    // 2: equal bins 3 and 9 -> lower index wins
    frm[3] = 32'h0100_0000;
    frm[9] = 32'h0100_0000;
    strobe();
    expect_result("t2", 4'd3);

    // 3: full-scale negative bin 12 beats max positive bin 0
    frm[0]  = 32'h7FFF_7FFF;
    frm[12] = 32'h8000_8000;
    strobe();
    expect_result("t3", 4'd12);

    // 4: three frames back to back, 16 cycles apart
    for (int i = 0; i < 16; i++) frm[i] = 32'h0001_0001;
    frm[2] = 32'h0010_0000;
    strobe();                                  // E0
    ticks(15);                                 // E15
    for (int i = 0; i < 16; i++) frm[i] = 32'h0002_FFFE;
    frm[14] = 32'hFF00_0000;
    frm[15] = 32'h0080_0000;
    strobe();                                  // E16
    chk("t4_a_nodone_e16", 32'(done), 32'd0);
    tick();                                    // E17
    chk("t4_a_done", 32'(done), 32'd1);
    chk("t4_a_freq", 32'(freq), 32'd2);
    chk("t4_busy_overlap", 32'(busy), 32'd1);
    ticks(14);                                 // E31
    for (int i = 0; i < 16; i++) frm[i] = 32'h0003_0000;
    frm[0] = 32'h0000_0400;
    strobe();                                  // E32
    chk("t4_b_nodone_e32", 32'(done), 32'd0);
    tick();                                    // E33
    chk("t4_b_done", 32'(done), 32'd1);
    chk("t4_b_freq", 32'(freq), 32'd14);
    ticks(16);                                 // E49
    chk("t4_c_done", 32'(done), 32'd1);
    chk("t4_c_freq", 32'(freq), 32'd0);
    chk("t4_overrun", 32'(overrun), 32'd0);

    // 5: second frame 8 cycles into a scan is dropped
    ticks(2);
    frm[7] = 32'h0200_0200;
    strobe();                                  // E0
    chk("t5_overrun_pre", 32'(overrun), 32'd0);
    ticks(7);                                  // E7
    frm[1] = 32'h7000_7000;
    strobe();                                  // E8
    chk("t5_overrun_set", 32'(overrun), 32'd1);
    ndone = 0;
    last_freq = 4'd0;
    for (int i = 9; i <= 40; i++) begin
      tick();
      if (done) begin
        ndone++;
        last_freq = freq;
      end
    end
    chk("t5_done_count", 32'(ndone), 32'd1);
    chk("t5_freq", 32'(last_freq), 32'd7);
    chk("t5_overrun_sticky", 32'(overrun), 32'd1);

    // 6: reset at idx 7 of a scan, then a clean frame
    frm[4] = 32'h0100_0100;
    strobe();                                  // E0, idx=0
    ticks(7);                                  // idx=7
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_freq_cleared", 32'(freq), 32'd0);
    chk("t6_busy_cleared", 32'(busy), 32'd0);
    chk("t6_overrun_cleared", 32'(overrun), 32'd0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("t6_no_done", 32'(ndone), 32'd0);
    frm[10] = 32'hFE00_0100;
    strobe();
    expect_result("t6_next", 4'd10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
